scpu_pc_int: RTL and testbench

- PC and interrupt-entry stage for the single-cycle interrupt-capable MIPS CPU.
- Sits directly upstream of the interrupt-aware main controller: it supplies `PC_out` for instruction fetch and drives `int_code`, the in-service flag the controller needs before it asserts `eret`.
- It consumes the controller's `Branch` and `eret` outputs to select the next PC.
- It captures external interrupt requests, saves the return address in `EPC`, vectors to the handler, and restores `EPC` on `eret`.

---
 rtl/scpu_pc_int_if.sv | 52 +++++
 rtl/scpu_pc_int.sv | 163 ++++++++++++++++
 tb/tb_scpu_pc_int.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/scpu_pc_int_if.sv
// -----------------------------------------------------------------------------
// scpu_pc_int_if
//   Bundle of signals between the PC / interrupt-entry stage and the rest of
//   the single-cycle CPU (controller, register file, memory-ready logic and the
//   external interrupt source).
//
//   slave  modport : used by scpu_pc_int itself
//       inputs  MIO_ready, Branch, eret, Inst, rs_data, INT
//       outputs PC_out, PC_4, int_code, EPC, int_ack
//   master modport : used by the surrounding CPU / testbench (directions mirrored)
// -----------------------------------------------------------------------------
interface scpu_pc_int_if;
    logic        MIO_ready;   // instruction boundary enable, 0 = stall
    logic [1:0]  Branch;      // next-PC select from the controller
    logic        eret;        // return from interrupt
    logic [25:0] Inst;        // jump target / imm16 field of current instruction
    logic [31:0] rs_data;     // jr/jalr target
    logic        INT;         // external interrupt request, level
    logic [31:0] PC_out;      // fetch address
    logic [31:0] PC_4;        // PC_out + 4, link value
    logic        int_code;    // in-service flag
    logic [31:0] EPC;         // saved return address
    logic        int_ack;     // one-cycle pulse after an interrupt is taken

    modport slave (
        input  MIO_ready,
        input  Branch,
        input  eret,
        input  Inst,
        input  rs_data,
        input  INT,
        output PC_out,
        output PC_4,
        output int_code,
        output EPC,
        output int_ack
    );

    modport master (
        output MIO_ready,
        output Branch,
        output eret,
        output Inst,
        output rs_data,
        output INT,
        input  PC_out,
        input  PC_4,
        input  int_code,
        input  EPC,
        input  int_ack
    );
endinterface

// File: rtl/scpu_pc_int.sv
// -----------------------------------------------------------------------------
// scpu_pc_int
//   PC and interrupt-entry stage of the single-cycle interrupt-capable MIPS CPU.
//   Computes the next PC from the controller's Branch select, captures rising
//   edges of the external interrupt request, saves the return address in EPC
//   and vectors to the handler, and restores EPC on eret.
//
//   Ports
//     clk   : system clock, all state changes on the rising edge
//     rst   : synchronous reset, active high, overrides everything
//     bus   : scpu_pc_int_if.slave
//               MIO_ready, Branch, eret, Inst, rs_data, INT  (in)
//               PC_out, PC_4, int_code, EPC, int_ack         (out)
//
//   Parameters
//     RESET_PC   : PC value loaded by reset
//     INT_VECTOR : interrupt handler entry address
// -----------------------------------------------------------------------------
module scpu_pc_int #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0004
) (
    input  logic          clk,
    input  logic          rst,
    scpu_pc_int_if.slave  bus
);

    // Two-state service machine; the state bit is exported directly as int_code.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SERVICE = 1'b1;

    // Controller next-PC select encodings.
    localparam logic [1:0] BR_SEQ = 2'b00;
    localparam logic [1:0] BR_REL = 2'b01;
    localparam logic [1:0] BR_JMP = 2'b10;
    localparam logic [1:0] BR_REG = 2'b11;

    // Architectural state.
    logic [31:0] pc_r;
    logic [31:0] epc_r;
    logic [0:0]  state_r;
    logic        pending_r;
    logic        int_d_r;
    logic        int_ack_r;

    // Next-state values.
    logic [31:0] pc_nxt_s;
    logic [31:0] epc_nxt_s;
    logic [0:0]  state_nxt_s;
    logic        pending_nxt_s;

    // Datapath and decision helpers.
    logic [31:0] pc_4_s;
    logic [31:0] rel_off_s;
    logic [31:0] rel_tgt_s;
    logic [31:0] jmp_tgt_s;
    logic [31:0] npc_s;
    logic        rise_s;
    logic        ret_s;
    logic        take_s;

    // Next-PC candidates; all adds wrap modulo 2^32.
    always_comb begin
        pc_4_s    = pc_r + 32'd4;
        rel_off_s = {{14{bus.Inst[15]}}, bus.Inst[15:0], 2'b00};
        rel_tgt_s = pc_4_s + rel_off_s;
        jmp_tgt_s = {pc_4_s[31:28], bus.Inst[25:0], 2'b00};
    end

    // Next-PC mux driven by the controller's Branch select.
    always_comb begin
        npc_s = pc_4_s;
        case (bus.Branch)
            BR_SEQ:  npc_s = pc_4_s;
            BR_REL:  npc_s = rel_tgt_s;
            BR_JMP:  npc_s = jmp_tgt_s;
            BR_REG:  npc_s = bus.rs_data;
            default: npc_s = pc_4_s;
        endcase
    end

    // Boundary decisions. A return has priority over a pending take in the same
    // cycle, so a request that arrived during service is taken one boundary
    // after the return, with EPC pointing past the first returned-to
    // instruction. eret outside service is ignored.
    always_comb begin
        rise_s = bus.INT & ~int_d_r;
        if (bus.MIO_ready && (state_r == ST_SERVICE) && bus.eret) begin
            ret_s  = 1'b1;
            take_s = 1'b0;
        end else if (bus.MIO_ready && (state_r == ST_IDLE) && pending_r) begin
            ret_s  = 1'b0;
            take_s = 1'b1;
        end else begin
            ret_s  = 1'b0;
            take_s = 1'b0;
        end
    end

    // Next-state selection for PC, EPC, service state and the pending latch.
    always_comb begin
        pc_nxt_s    = pc_r;
        epc_nxt_s   = epc_r;
        state_nxt_s = state_r;
        if (!bus.MIO_ready) begin
            // Stall: architectural state held.
            pc_nxt_s    = pc_r;
            epc_nxt_s   = epc_r;
            state_nxt_s = state_r;
        end else if (ret_s) begin
            pc_nxt_s    = epc_r;
            epc_nxt_s   = epc_r;
            state_nxt_s = ST_IDLE;
        end else if (take_s) begin
            // The current instruction still completes; EPC gets whatever it
            // would have fetched next, including a taken branch/jump target.
            pc_nxt_s    = INT_VECTOR;
            epc_nxt_s   = npc_s;
            state_nxt_s = ST_SERVICE;
        end else begin
            pc_nxt_s    = npc_s;
            epc_nxt_s   = epc_r;
            state_nxt_s = state_r;
        end

        // A fresh edge in the same cycle as a take re-arms pending (set wins).
        if (rise_s) begin
            pending_nxt_s = 1'b1;
        end else if (take_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // State registers with synchronous reset; edge history sampled every cycle
    // regardless of stalls so edges arriving during a stall are not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            epc_r     <= 32'h0000_0000;
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            int_d_r   <= 1'b0;
            int_ack_r <= 1'b0;
        end else begin
            pc_r      <= pc_nxt_s;
            epc_r     <= epc_nxt_s;
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            int_d_r   <= bus.INT;
            int_ack_r <= take_s;
        end
    end

    // Output drive; PC_4 is intentionally combinational for same-cycle jal links.
    assign bus.PC_out   = pc_r;
    assign bus.PC_4     = pc_4_s;
    assign bus.int_code = state_r[0];
    assign bus.EPC      = epc_r;
    assign bus.int_ack  = int_ack_r;

endmodule

// File: tb/tb_scpu_pc_int.sv
module tb_scpu_pc_int;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   ack_cnt;

    scpu_pc_int_if bus_if ();

    scpu_pc_int #(
        .RESET_PC   (32'h0000_0000),
        .INT_VECTOR (32'h0000_0004)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report a mismatch.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ack_cnt  = 0;
        rst              = 1'b1;
        bus_if.MIO_ready = 1'b1;
        bus_if.Branch    = 2'b00;
        bus_if.eret      = 1'b0;
        bus_if.Inst      = 26'h0000000;
        bus_if.rs_data   = 32'h0000_0000;
        bus_if.INT       = 1'b0;

        // Reset
        step();
        step();
        check_val("rst_pc",   bus_if.PC_out,   32'h0);
        check_val("rst_pc4",  bus_if.PC_4,     32'h4);
        check_val("rst_int",  {31'd0, bus_if.int_code}, 32'd0);
        check_val("rst_epc",  bus_if.EPC,      32'h0);
        check_val("rst_ack",  {31'd0, bus_if.int_ack},  32'd0);
        rst = 1'b0;

        // Sequential fetch
        step(); check_val("seq_4", bus_if.PC_out, 32'h4);
        step(); check_val("seq_8", bus_if.PC_out, 32'h8);
        step(); check_val("seq_c", bus_if.PC_out, 32'hC);
        check_val("seq_intc", {31'd0, bus_if.int_code}, 32'd0);
        check_val("seq_epc",  bus_if.EPC, 32'h0);
        step(); check_val("seq_10", bus_if.PC_out, 32'h10);

        // Relative branch backwards: 0x14 + (-2<<2) = 0x0C
        bus_if.Branch = 2'b01;
        bus_if.Inst   = 26'h000FFFE;
        check_val("pc4_10", bus_if.PC_4, 32'h14);
        step(); check_val("br_rel", bus_if.PC_out, 32'h0C);

        // Back to 0x10, then j 0x100 -> 0x400
        bus_if.Branch = 2'b00;
        step(); check_val("back_10a", bus_if.PC_out, 32'h10);
        bus_if.Branch = 2'b10;
        bus_if.Inst   = 26'h0000100;
        step(); check_val("br_jmp", bus_if.PC_out, 32'h400);

        // jr 0x10 then jr 0x80
        bus_if.Branch  = 2'b11;
        bus_if.rs_data = 32'h10;
        step(); check_val("back_10b", bus_if.PC_out, 32'h10);
        bus_if.rs_data = 32'h80;
        step(); check_val("br_reg", bus_if.PC_out, 32'h80);

        // eret outside service is ignored
        bus_if.Branch = 2'b00;
        bus_if.eret   = 1'b1;
        step(); check_val("eret_idle_pc", bus_if.PC_out, 32'h84);
        check_val("eret_idle_intc", {31'd0, bus_if.int_code}, 32'd0);
        bus_if.eret = 1'b0;

        // Interrupt entry around PC=0x20
        bus_if.Branch  = 2'b11;
        bus_if.rs_data = 32'h1C;
        step(); check_val("to_1c", bus_if.PC_out, 32'h1C);
        bus_if.Branch = 2'b00;
        bus_if.INT    = 1'b1;
        step(); check_val("edge_pc", bus_if.PC_out, 32'h20);
        check_val("edge_intc", {31'd0, bus_if.int_code}, 32'd0);
        bus_if.INT = 1'b0;
        step();
        check_val("take_pc",   bus_if.PC_out, 32'h4);
        check_val("take_epc",  bus_if.EPC,    32'h24);
        check_val("take_intc", {31'd0, bus_if.int_code}, 32'd1);
        check_val("take_ack",  {31'd0, bus_if.int_ack},  32'd1);
        step();
        check_val("hdl_pc",   bus_if.PC_out, 32'h8);
        check_val("hdl_ack0", {31'd0, bus_if.int_ack}, 32'd0);
        bus_if.eret = 1'b1;
        step();
        check_val("ret_pc",   bus_if.PC_out, 32'h24);
        check_val("ret_intc", {31'd0, bus_if.int_code}, 32'd0);
        bus_if.eret = 1'b0;

        // INT held high 10 cycles -> exactly one take
        bus_if.Branch  = 2'b11;
        bus_if.rs_data = 32'h1C;
        step();
        bus_if.Branch = 2'b00;
        bus_if.INT    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_if.int_ack) ack_cnt++;
        end
        check_val("held_acks", ack_cnt, 32'd1);
        check_val("held_epc",  bus_if.EPC, 32'h24);
        check_val("held_pc",   bus_if.PC_out, 32'h24);
        check_val("held_intc", {31'd0, bus_if.int_code}, 32'd1);

        // Second edge during service waits for eret, then one more boundary
        bus_if.INT = 1'b0;
        step();
        bus_if.INT = 1'b1;
        step();
        bus_if.INT  = 1'b0;
        bus_if.eret = 1'b1;
        step();
        check_val("nest_ret_pc",   bus_if.PC_out, 32'h24);
        check_val("nest_ret_intc", {31'd0, bus_if.int_code}, 32'd0);
        check_val("nest_ret_ack",  {31'd0, bus_if.int_ack},  32'd0);
        bus_if.eret = 1'b0;
        step();
        check_val("nest_take_pc",  bus_if.PC_out, 32'h4);
        check_val("nest_take_epc", bus_if.EPC,    32'h28);
        check_val("nest_take_ack", {31'd0, bus_if.int_ack}, 32'd1);
        bus_if.eret = 1'b1;
        step();
        check_val("nest_ret2_pc", bus_if.PC_out, 32'h28);
        bus_if.eret = 1'b0;

        // Stall for 3 cycles while an edge arrives
        bus_if.MIO_ready = 1'b0;
        bus_if.INT       = 1'b1;
        step();
        bus_if.INT = 1'b0;
        step();
        step();
        check_val("stall_pc",   bus_if.PC_out, 32'h28);
        check_val("stall_intc", {31'd0, bus_if.int_code}, 32'd0);
        check_val("stall_epc",  bus_if.EPC, 32'h28);
        bus_if.MIO_ready = 1'b1;
        step();
        check_val("stall_take_pc",  bus_if.PC_out, 32'h4);
        check_val("stall_take_epc", bus_if.EPC,    32'h2C);
        check_val("stall_take_intc", {31'd0, bus_if.int_code}, 32'd1);

        // Reset while in service with a pending request
        bus_if.INT = 1'b1;
        step();
        bus_if.INT = 1'b0;
        check_val("pre_rst_pc", bus_if.PC_out, 32'h8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst2_pc",   bus_if.PC_out, 32'h0);
        check_val("rst2_intc", {31'd0, bus_if.int_code}, 32'd0);
        check_val("rst2_epc",  bus_if.EPC, 32'h0);
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_if.int_ack) ack_cnt++;
        end
        check_val("rst2_noack", ack_cnt, 32'd0);
        check_val("rst2_pc_after", bus_if.PC_out, 32'h10);
        check_val("rst2_intc_after", {31'd0, bus_if.int_code}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
